// File: rtl/input_pkg.sv
// Shared types and default constants for the switch/button input conditioner.
package input_pkg;

    // Per-channel debounce state: two stable levels plus a pending state for each direction.
    typedef enum logic [1:0] {
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } db_state_t;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;

    // 10 ms at 100 MHz gives 1_000_000 stable edges.
    localparam int unsigned DEFAULT_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, stable-time debounce FSM and edge pulses.
module debounce_channel
    import input_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // A single-edge qualification window would make the pending states meaningless.
    if (STABLE_CYCLES < 2) begin : g_bad_cfg
        $error("debounce_channel: STABLE_CYCLES must be >= 2");
    end

    logic             meta_q;
    logic             sync_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Bring the asynchronous pad into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // Debounce state, qualification counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next state: count consecutive differing edges; any agreeing edge drops back and clears the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                cnt_d = '0;
                if (sync_q) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_HI: begin
                if (!sync_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                cnt_d = '0;
                if (!sync_q) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_LO: begin
                if (sync_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                clean_d = 1'b0;
            end
        endcase
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Board input conditioner: one independent debounce channel per switch/button pin.
module input_conditioner
    import input_pkg::*;
#(
    parameter int unsigned WIDTH         = 20,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] clean_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    // Channels share nothing but clock and reset.
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (raw_i[g]),
            .clean_o(clean_o[g]),
            .rise_o (rise_o[g]),
            .fall_o (fall_o[g])
        );
    end

endmodule
